buffered_matrixn_colorspace_converter: RTL and testbench



---
 rtl/edge_detect_pkg.sv | 21 ++
 rtl/line_buffer_n.sv | 30 +++
 rtl/buffered_matrixn_colorspace_converter.sv | 184 ++++++++++++++++++
 tb/tb_buffered_matrixn_colorspace_converter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// rtl/edge_detect_pkg.sv - shared constants, frame states and window indexing for the NxN grayscale window builder
package edge_detect_pkg;

  localparam int GRAY_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } frame_state_e;

  function automatic int half_window(input int n);
    return (n - 1) / 2;
  endfunction

  // Row-major packing: (0,0) occupies the MSBs, (n-1,n-1) the LSBs.
  function automatic int window_lsb(input int row, input int col, input int n, input int w);
    return ((n * n - 1) - (row * n + col)) * w;
  endfunction

endpackage

// File: rtl/line_buffer_n.sv
// rtl/line_buffer_n.sv - multi-line buffer, one write port, all lines read in parallel at one column
module line_buffer_n #(
  parameter int P_LINES       = 2,
  parameter int P_COLUMNS     = 640,
  parameter int P_DATA_BITS   = 8,
  parameter int P_COLUMN_BITS = $clog2(P_COLUMNS),
  parameter int P_LINE_BITS   = (P_LINES > 1) ? $clog2(P_LINES) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 wr_en_i,
  input  logic [P_LINE_BITS-1:0]               wr_line_i,
  input  logic [P_COLUMN_BITS-1:0]             column_i,
  input  logic [P_DATA_BITS-1:0]               wr_data_i,
  output logic [P_LINES-1:0][P_DATA_BITS-1:0]  rd_data_o
);

  logic [P_DATA_BITS-1:0] mem_q [P_LINES][P_COLUMNS];

  // Reads are combinational so a same-column write lands after the old value is seen.
  for (genvar l = 0; l < P_LINES; l++) begin : g_rd
    assign rd_data_o[l] = mem_q[l][column_i];
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_line_i][column_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/buffered_matrixn_colorspace_converter.sv
// rtl/buffered_matrixn_colorspace_converter.sv - RGB stream to grayscale NxN sliding windows with centre coordinates
module buffered_matrixn_colorspace_converter
  import edge_detect_pkg::*;
#(
  parameter int P_FRAME_COLUMNS     = 640,
  parameter int P_FRAME_ROWS        = 480,
  parameter int P_PIXEL_DEPTH       = 24,
  parameter int P_WINDOW_SIZE       = 3,
  parameter int P_FRAME_COLUMN_BITS = $clog2(P_FRAME_COLUMNS),
  parameter int P_FRAME_ROW_BITS    = $clog2(P_FRAME_ROWS),
  parameter int P_SUBPIXEL_DEPTH    = P_PIXEL_DEPTH / 3,
  parameter int P_PIXEL_MATRIX_BITS = P_SUBPIXEL_DEPTH * P_WINDOW_SIZE * P_WINDOW_SIZE
) (
  input  logic                           I_CLK,
  input  logic                           I_RESET,
  input  logic                           I_PIXEL_VALID,
  input  logic                           I_FRAME_START,
  input  logic [P_PIXEL_DEPTH-1:0]       I_PIXEL,
  output logic [P_FRAME_COLUMN_BITS-1:0] O_PIXEL_COLUMN,
  output logic [P_FRAME_ROW_BITS-1:0]    O_PIXEL_ROW,
  output logic [P_PIXEL_MATRIX_BITS-1:0] O_PIXEL_MATRIX,
  output logic                           O_PIXEL_MATRIX_READY,
  output logic                           O_FRAME_ABORT
);

  localparam int N     = P_WINDOW_SIZE;
  localparam int W     = P_SUBPIXEL_DEPTH;
  localparam int CB    = P_FRAME_COLUMN_BITS;
  localparam int RB    = P_FRAME_ROW_BITS;
  localparam int LINES = N - 1;
  localparam int LB    = $clog2(LINES);
  localparam int H     = half_window(N);
  localparam logic [CB-1:0] LAST_COL = CB'(P_FRAME_COLUMNS - 1);
  localparam logic [RB-1:0] LAST_ROW = RB'(P_FRAME_ROWS - 1);

  frame_state_e  state_q, state_d;
  logic [CB-1:0] col_q, col_d, acc_col;
  logic [RB-1:0] row_q, row_d, acc_row;
  logic          accept, abort;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    accept  = 1'b0;
    abort   = 1'b0;
    acc_col = col_q;
    acc_row = row_q;
    if (I_PIXEL_VALID) begin
      if (I_FRAME_START) begin
        accept  = 1'b1;
        acc_col = '0;
        acc_row = '0;
        abort   = (state_q == ST_ACTIVE) && ((col_q != '0) || (row_q != '0));
      end else if (state_q == ST_ACTIVE) begin
        accept = 1'b1;
      end
    end
    if (accept) begin
      state_d = ST_ACTIVE;
      col_d   = acc_col + 1'b1;
      row_d   = acc_row;
      if (acc_col == LAST_COL) begin
        col_d = '0;
        row_d = acc_row + 1'b1;
        if (acc_row == LAST_ROW) begin
          row_d   = '0;
          state_d = ST_DONE;
        end
      end
    end
  end

  logic [W+1:0] gray_sum;
  logic [W-1:0] gray_new;
  assign gray_sum = {2'b00, I_PIXEL[3*W-1:2*W]} + {1'b0, I_PIXEL[2*W-1:W], 1'b0}
                  + {2'b00, I_PIXEL[W-1:0]};
  assign gray_new = W'(gray_sum >> GRAY_SHIFT);

  logic          s1_valid_q, s1_abort_q;
  logic [CB-1:0] s1_col_q;
  logic [RB-1:0] s1_row_q;
  logic [W-1:0]  s1_gray_q;

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      s1_valid_q <= accept;
      s1_abort_q <= abort;
    end
    s1_col_q  <= acc_col;
    s1_row_q  <= acc_row;
    s1_gray_q <= gray_new;
  end

  // line_cur always equals row mod (N-1); it restarts at 0 on every frame's first pixel.
  logic [LB-1:0] line_q, line_d, line_cur;
  assign line_cur = ((s1_col_q == '0) && (s1_row_q == '0)) ? '0 : line_q;

  always_comb begin
    line_d = line_q;
    if (s1_valid_q) begin
      line_d = line_cur;
      if (s1_col_q == LAST_COL) begin
        line_d = (line_cur == LB'(LINES - 1)) ? '0 : line_cur + 1'b1;
      end
    end
  end

  logic [LINES-1:0][W-1:0] rd_lines, col_new;

  line_buffer_n #(
    .P_LINES      (LINES),
    .P_COLUMNS    (P_FRAME_COLUMNS),
    .P_DATA_BITS  (W),
    .P_COLUMN_BITS(CB),
    .P_LINE_BITS  (LB)
  ) u_line_buffer (
    .clk_i    (I_CLK),
    .wr_en_i  (s1_valid_q),
    .wr_line_i(line_cur),
    .column_i (s1_col_q),
    .wr_data_i(s1_gray_q),
    .rd_data_o(rd_lines)
  );

  // Oldest buffered line (about to be overwritten) goes to the top of the new column.
  for (genvar k = 0; k < LINES; k++) begin : g_newcol
    logic [LB:0] sum;
    assign sum = {1'b0, line_cur} + (LB+1)'(k);
    assign col_new[k] = (sum >= (LB+1)'(LINES)) ? rd_lines[LB'(sum - (LB+1)'(LINES))]
                                                 : rd_lines[sum[LB-1:0]];
  end

  logic [P_PIXEL_MATRIX_BITS-1:0] win_q, win_d;

  for (genvar r = 0; r < N; r++) begin : g_wrow
    for (genvar c = 0; c < N; c++) begin : g_wcol
      localparam int LSB = window_lsb(r, c, N, W);
      if (c < N - 1) begin : g_shift
        assign win_d[LSB +: W] = win_q[window_lsb(r, c + 1, N, W) +: W];
      end else if (r < N - 1) begin : g_buf
        assign win_d[LSB +: W] = col_new[r];
      end else begin : g_new
        assign win_d[LSB +: W] = s1_gray_q;
      end
    end
  end

  logic emit;
  assign emit = s1_valid_q && (s1_row_q >= RB'(N - 1)) && (s1_col_q >= CB'(N - 1));

  always_ff @(posedge I_CLK) begin
    if (s1_valid_q) begin
      win_q <= win_d;
    end
    if (I_RESET) begin
      line_q               <= '0;
      O_PIXEL_COLUMN       <= '0;
      O_PIXEL_ROW          <= '0;
      O_PIXEL_MATRIX       <= '0;
      O_PIXEL_MATRIX_READY <= 1'b0;
      O_FRAME_ABORT        <= 1'b0;
    end else begin
      line_q               <= line_d;
      O_PIXEL_MATRIX_READY <= emit;
      O_FRAME_ABORT        <= s1_abort_q;
      if (emit) begin
        O_PIXEL_MATRIX <= win_d;
        O_PIXEL_COLUMN <= s1_col_q - CB'(H);
        O_PIXEL_ROW    <= s1_row_q - RB'(H);
      end
    end
  end

endmodule

// File: tb/tb_buffered_matrixn_colorspace_converter.sv
// tb/tb_buffered_matrixn_colorspace_converter.sv - scoreboard bench for N=3 and N=5 instances on an 8x6 frame
module tb_buffered_matrixn_colorspace_converter;

  localparam int COLS = 8;
  localparam int ROWS = 6;

  logic        clk = 1'b0;
  logic        rst, vld, fs;
  logic [23:0] pix;
  always #5 clk = ~clk;

  logic [2:0]   col3, row3, col5, row5;
  logic [71:0]  mat3;
  logic [199:0] mat5;
  logic         rdy3, ab3, rdy5, ab5;

  buffered_matrixn_colorspace_converter #(
    .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24), .P_WINDOW_SIZE(3)
  ) dut3 (
    .I_CLK(clk), .I_RESET(rst), .I_PIXEL_VALID(vld), .I_FRAME_START(fs), .I_PIXEL(pix),
    .O_PIXEL_COLUMN(col3), .O_PIXEL_ROW(row3), .O_PIXEL_MATRIX(mat3),
    .O_PIXEL_MATRIX_READY(rdy3), .O_FRAME_ABORT(ab3)
  );

  buffered_matrixn_colorspace_converter #(
    .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_PIXEL_DEPTH(24), .P_WINDOW_SIZE(5)
  ) dut5 (
    .I_CLK(clk), .I_RESET(rst), .I_PIXEL_VALID(vld), .I_FRAME_START(fs), .I_PIXEL(pix),
    .O_PIXEL_COLUMN(col5), .O_PIXEL_ROW(row5), .O_PIXEL_MATRIX(mat5),
    .O_PIXEL_MATRIX_READY(rdy5), .O_FRAME_ABORT(ab5)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           due;
    int           r;
    int           c;
    logic [199:0] mat;
  } exp_t;

  exp_t        q3[$];
  exp_t        q5[$];
  int          abort_due = -100;
  logic [7:0]  img [ROWS][COLS];
  int          m_state = 0;
  int          m_r = 0;
  int          m_c = 0;

  int           win_cnt [2];
  int           ab_cnt [2];
  logic [199:0] first_mat [2];
  logic [199:0] first_r [2];
  logic [199:0] first_c [2];
  logic [199:0] last_r [2];
  logic [199:0] last_c [2];

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int s;
    s = int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 4);
  endfunction

  function automatic exp_t make_exp(input int n, input int r, input int c, input int due);
    exp_t e;
    e.due = due;
    e.r   = r - (n - 1) / 2;
    e.c   = c - (n - 1) / 2;
    e.mat = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        e.mat[((n * n - 1) - (i * n + j)) * 8 +: 8] = img[r - n + 1 + i][c - n + 1 + j];
    return e;
  endfunction

  task automatic drive(input logic v, input logic f, input logic [23:0] p);
    bit acc;
    int r, c;
    @(negedge clk);
    vld = v;
    fs  = f;
    pix = p;
    acc = 1'b0;
    if (v && f) begin
      if (m_state == 1 && !(m_r == 0 && m_c == 0)) abort_due = cyc + 2;
      m_r = 0;
      m_c = 0;
      acc = 1'b1;
    end else if (v && m_state == 1) begin
      acc = 1'b1;
    end
    if (acc) begin
      r = m_r;
      c = m_c;
      img[r][c] = gray_of(p);
      if (r >= 2 && c >= 2) q3.push_back(make_exp(3, r, c, cyc + 2));
      if (r >= 4 && c >= 4) q5.push_back(make_exp(5, r, c, cyc + 2));
      m_state = 1;
      if (c == COLS - 1) begin
        m_c = 0;
        if (r == ROWS - 1) begin
          m_r = 0;
          m_state = 2;
        end else begin
          m_r = r + 1;
        end
      end else begin
        m_c = c + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 24'h0);
  endtask

  task automatic send_frame(input int base, input int gap, input int npix, input bit gray_mode);
    int r, c;
    logic [7:0]  v;
    logic [23:0] p;
    for (int i = 0; i < npix; i++) begin
      r = i / COLS;
      c = i % COLS;
      v = 8'(base + 8 * r + c);
      p = {v, v, v};
      if (gray_mode) p = (i == 0) ? 24'hFF00FF : (i == 1) ? 24'hFFFFFF : 24'($urandom);
      drive(1'b1, i == 0, p);
      idle(gap);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 2; k++) begin
      win_cnt[k] = 0;
      ab_cnt[k]  = 0;
    end
  endtask

  task automatic mon(input int k, input logic rdy, input logic [199:0] oc,
                     input logic [199:0] orow, input logic [199:0] om, input logic ab);
    bit    e;
    exp_t  x;
    string tg;
    tg = (k == 0) ? "n3" : "n5";
    if (k == 0) e = (q3.size() > 0) && (q3[0].due == cyc);
    else        e = (q5.size() > 0) && (q5[0].due == cyc);
    chk({tg, "_ready"}, {199'b0, rdy}, {199'b0, e});
    if (rdy === 1'b1) begin
      if (win_cnt[k] == 0) begin
        first_mat[k] = om;
        first_r[k]   = orow;
        first_c[k]   = oc;
      end
      win_cnt[k]++;
      last_r[k] = orow;
      last_c[k] = oc;
    end
    if (ab === 1'b1) ab_cnt[k]++;
    if (e) begin
      if (k == 0) x = q3.pop_front();
      else        x = q5.pop_front();
      chk({tg, "_centre_row"}, orow, 200'(x.r));
      chk({tg, "_centre_col"}, oc, 200'(x.c));
      chk({tg, "_matrix"}, om, x.mat);
    end
    chk({tg, "_abort"}, {199'b0, ab}, {199'b0, cyc == abort_due});
  endtask

  always @(negedge clk) begin
    mon(0, rdy3, {197'b0, col3}, {197'b0, row3}, {128'b0, mat3}, ab3);
    mon(1, rdy5, {197'b0, col5}, {197'b0, row5}, mat5, ab5);
  end

  initial begin
    rst = 1'b1;
    vld = 1'b0;
    fs  = 1'b0;
    pix = 24'h0;
    clear_stats();
    repeat (2) @(negedge clk);
    chk("reset_n3", {128'b0, mat3, col3, row3, rdy3, ab3}, '0);
    chk("reset_n5", {mat5[119:0], col5, row5, rdy5, ab5, 72'b0}, '0);
    chk("reset_n5_hi", {120'b0, mat5[199:120]}, '0);
    rst = 1'b0;

    // Full-rate 8x6 ramp frame.
    idle(2);
    send_frame(0, 0, COLS * ROWS, 1'b0);
    idle(4);
    chk("a_count_n3", 200'(win_cnt[0]), 200'd24);
    chk("a_first_mat_n3", first_mat[0], {128'b0, 72'h000102_08090A_101112});
    chk("a_first_row_n3", first_r[0], 200'd1);
    chk("a_first_col_n3", first_c[0], 200'd1);
    chk("a_last_row_n3", last_r[0], 200'd4);
    chk("a_last_col_n3", last_c[0], 200'd6);
    chk("a_count_n5", 200'(win_cnt[1]), 200'd8);
    chk("a_first_tl_n5", {192'b0, first_mat[1][199:192]}, 200'h00);
    chk("a_first_br_n5", {192'b0, first_mat[1][7:0]}, 200'd36);
    chk("a_first_row_n5", first_r[1], 200'd2);
    chk("a_first_col_n5", first_c[1], 200'd2);

    // Same frame, valid every third cycle.
    clear_stats();
    send_frame(0, 2, COLS * ROWS, 1'b0);
    idle(4);
    chk("b_count_n3", 200'(win_cnt[0]), 200'd24);
    chk("b_first_mat_n3", first_mat[0], {128'b0, 72'h000102_08090A_101112});
    chk("b_last_col_n3", last_c[0], 200'd6);
    chk("b_count_n5", 200'(win_cnt[1]), 200'd8);

    // Grayscale corner values at (0,0) and (0,1).
    clear_stats();
    send_frame(0, 0, COLS * ROWS, 1'b1);
    idle(4);
    chk("gray_ff00ff", {192'b0, first_mat[0][71:64]}, 200'h7F);
    chk("gray_ffffff", {192'b0, first_mat[0][63:56]}, 200'hFF);

    // Frame start at (3,5): frame 1 gives 6+3 windows for N=3, none for N=5.
    clear_stats();
    send_frame(100, 0, 3 * COLS + 5, 1'b0);
    send_frame(0, 0, COLS * ROWS, 1'b0);
    idle(4);
    chk("abort_pulses_n3", 200'(ab_cnt[0]), 200'd1);
    chk("abort_pulses_n5", 200'(ab_cnt[1]), 200'd1);
    chk("abort_count_n3", 200'(win_cnt[0]), 200'd33);
    chk("abort_count_n5", 200'(win_cnt[1]), 200'd8);

    // One-cycle reset in the middle of row 3.
    send_frame(0, 0, 3 * COLS + 3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    vld = 1'b0;
    fs  = 1'b0;
    #1;
    q3.delete();
    q5.delete();
    abort_due = -100;
    m_state = 0;
    m_r = 0;
    m_c = 0;
    @(negedge clk);
    chk("rst_mid_n3", {128'b0, mat3, col3, row3, rdy3, ab3}, '0);
    chk("rst_mid_n5", {120'b0, (mat5 != '0), col5, row5, rdy5, ab5}, '0);
    rst = 1'b0;
    clear_stats();
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 24'(i * 3 + 1));
    idle(3);
    chk("rst_ignored_n3", 200'(win_cnt[0]), 200'd0);
    chk("rst_ignored_n5", 200'(win_cnt[1]), 200'd0);
    send_frame(0, 0, COLS * ROWS, 1'b0);
    idle(4);
    chk("rst_recover_n3", 200'(win_cnt[0]), 200'd24);
    chk("rst_recover_n5", 200'(win_cnt[1]), 200'd8);

    idle(3);
    chk("drain_q3", 200'(q3.size()), 200'd0);
    chk("drain_q5", 200'(q5.size()), 200'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
